// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and gap counter sizing.
package serializer_pkg;

    // IDLE: no word in flight. SHIFT: data_o shows a bit this cycle. GAP: idle spacing cycles.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } ser_state_e;

    // Wide enough for the largest supported inter-bit gap (15 cycles).
    localparam int unsigned GapCntW = 4;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with a two-deep word buffer (shift register + holding register).
// Every output is a flop; a word accepted into an empty block shows its first bit the next cycle.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned GAP       = 0,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic             data_o,
    output logic             data_val_o,
    output logic             word_start_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int unsigned           CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]       CntLast = CntW'(WIDTH - 1);
    localparam logic [GapCntW-1:0]    GapLast = (GAP == 0) ? '0 : GapCntW'(GAP - 1);

    // Bit that leaves the word first, according to the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit consumed, so the next bit to send sits in the leading position.
    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    ser_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [GapCntW-1:0]  gap_q, gap_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [WIDTH-1:0]    hold_q, hold_d;
    logic                shift_vld_q, shift_vld_d;
    logic                hold_vld_q, hold_vld_d;

    logic                ready_q, ready_d;
    logic                data_q, data_d;
    logic                dval_q, dval_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic                last_bit;
    logic                emit;
    logic                new_word;
    logic [WIDTH-1:0]    src;
    logic [WIDTH-1:0]    next_word;

    assign accept   = s_valid_i & ready_q;
    // The shift register's word is on data_o for the final time this cycle.
    assign last_bit = (state_q == StShift) && (cnt_q == CntLast);

    // Next-state logic: word routing between the two slots and bit sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        shift_d     = shift_q;
        shift_vld_d = shift_vld_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        emit        = 1'b0;
        new_word    = 1'b0;
        src         = shift_q;
        next_word   = hold_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    emit        = 1'b1;
                    new_word    = 1'b1;
                    src         = s_data_i;
                    shift_vld_d = 1'b1;
                end
            end

            StShift: begin
                if (last_bit) begin
                    if (hold_vld_q || accept) begin
                        // Ready is low while holding is full, so at most one source is live here.
                        next_word  = hold_vld_q ? hold_q : s_data_i;
                        hold_vld_d = 1'b0;
                        if (GAP == 0) begin
                            emit     = 1'b1;
                            new_word = 1'b1;
                            src      = next_word;
                        end else begin
                            // Park the next word unshifted; cnt stays at the last index so the
                            // end of the gap knows to start a fresh word.
                            shift_d = next_word;
                            gap_d   = '0;
                            state_d = StGap;
                        end
                    end else begin
                        shift_vld_d = 1'b0;
                        state_d     = StIdle;
                    end
                end else begin
                    if (GAP == 0) begin
                        emit = 1'b1;
                    end else begin
                        gap_d   = '0;
                        state_d = StGap;
                    end
                    if (accept) begin
                        hold_d     = s_data_i;
                        hold_vld_d = 1'b1;
                    end
                end
            end

            StGap: begin
                if (gap_q == GapLast) begin
                    emit     = 1'b1;
                    new_word = (cnt_q == CntLast);
                end else begin
                    gap_d = gap_q + 1'b1;
                end
                // A word always occupies the shift register during a gap.
                if (accept) begin
                    hold_d     = s_data_i;
                    hold_vld_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (emit) begin
            shift_d = drop_bit(src);
            cnt_d   = new_word ? '0 : cnt_q + 1'b1;
            state_d = StShift;
        end
    end

    // Registered output values, derived from the same cycle's next-state decisions.
    always_comb begin
        dval_d  = emit;
        data_d  = emit & first_bit(src);
        start_d = emit & new_word;
        done_d  = emit & (cnt_d == CntLast);
        busy_d  = shift_vld_d | hold_vld_d;
        ready_d = ~hold_vld_d;
    end

    // FSM, counters and word slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            gap_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            shift_vld_q <= 1'b0;
            hold_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            shift_vld_q <= shift_vld_d;
            hold_vld_q  <= hold_vld_d;
        end
    end

    // Output flops; ready stays low in reset and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            data_q  <= 1'b0;
            dval_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign s_ready_o    = ready_q;
    assign data_o       = data_q;
    assign data_val_o   = dval_q;
    assign word_start_o = start_q;
    assign word_done_o  = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: three configurations (32b/gap0/MSB, 8b/gap2/MSB,
// 8b/gap0/LSB). Drivers push expected strobes; one monitor pops and checks them.
module tb_word_serializer;

    typedef struct {
        int   id;
        int   idx;
        int   edge_n;
        logic b;
        logic st;
        logic dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sd0;
    logic [7:0]  sd1;
    logic [7:0]  sd2;
    logic [2:0]  sv;
    wire  [2:0]  rdy, dout, dv, ws, wd, bsy;

    int          cyc = 0;
    int          vectors = 0;
    int          miss = 0;
    int          wsz [3] = '{32, 8, 8};
    int          gsz [3] = '{0, 2, 0};
    int          msb [3] = '{1, 1, 0};
    int          last_e [3] = '{-1000, -1000, -1000};
    int          strobes [3] = '{0, 0, 0};
    exp_t        expq [$];
    logic [31:0] wq [$];
    logic [31:0] rx = '0;
    exp_t        mon_e;
    logic [31:0] mon_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_serializer #(.WIDTH(32), .GAP(0), .MSB_FIRST(1)) u_ser32 (
        .clk(clk), .rst_n(rst_n), .s_data_i(sd0), .s_valid_i(sv[0]), .s_ready_o(rdy[0]),
        .data_o(dout[0]), .data_val_o(dv[0]), .word_start_o(ws[0]), .word_done_o(wd[0]),
        .busy_o(bsy[0])
    );
    word_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u_ser8g2 (
        .clk(clk), .rst_n(rst_n), .s_data_i(sd1), .s_valid_i(sv[1]), .s_ready_o(rdy[1]),
        .data_o(dout[1]), .data_val_o(dv[1]), .word_start_o(ws[1]), .word_done_o(wd[1]),
        .busy_o(bsy[1])
    );
    word_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u_ser8lsb (
        .clk(clk), .rst_n(rst_n), .s_data_i(sd2), .s_valid_i(sv[2]), .s_ready_o(rdy[2]),
        .data_o(dout[2]), .data_val_o(dv[2]), .word_start_o(ws[2]), .word_done_o(wd[2]),
        .busy_o(bsy[2])
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops one expected strobe per data_val_o; checks quiet outputs otherwise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
                strobes[i]++;
                vectors++;
                if (expq.size() == 0 || expq[0].id != i) begin
                    miss++;
                    $display("FAIL stray_strobe dut%0d: got strobe bit=%b at edge %0d, expected none",
                             i, dout[i], cyc);
                end else begin
                    mon_e = expq.pop_front();
                    if (cyc != mon_e.edge_n || dout[i] !== mon_e.b || ws[i] !== mon_e.st ||
                        wd[i] !== mon_e.dn) begin
                        miss++;
                        $display("FAIL strobe dut%0d bit%0d: got edge=%0d d=%b st=%b dn=%b, expected edge=%0d d=%b st=%b dn=%b",
                                 i, mon_e.idx, cyc, dout[i], ws[i], wd[i],
                                 mon_e.edge_n, mon_e.b, mon_e.st, mon_e.dn);
                    end
                end
                if (i == 0) begin
                    rx = {rx[30:0], dout[0]};
                    if (wd[0]) begin
                        if (wq.size() == 0) begin
                            vectors++;
                            miss++;
                            $display("FAIL rx_word: got %h, expected no word", rx);
                        end else begin
                            mon_w = wq.pop_front();
                            chk("rx_word", 64'(rx), 64'(mon_w));
                        end
                    end
                end
            end else begin
                chk($sformatf("quiet_outputs_dut%0d", i), 64'({dout[i], ws[i], wd[i]}), 64'(0));
            end
        end
    end

    task automatic set_in(input int id, input logic [31:0] w, input logic v);
        case (id)
            0:       sd0 = w;
            1:       sd1 = w[7:0];
            default: sd2 = w[7:0];
        endcase
        sv[id] = v;
    endtask

    // Present a word at a negedge, wait for acceptance, schedule its expected strobes.
    task automatic send(input int id, input logic [31:0] w);
        int   n;
        int   a;
        int   s0;
        exp_t e;
        set_in(id, w, 1'b1);
        n = 0;
        while (!rdy[id] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[id]) begin
            vectors++;
            miss++;
            $display("FAIL accept_timeout dut%0d: got ready=0 for 400 cycles, expected 1", id);
            set_in(id, w, 1'b0);
            return;
        end
        a  = cyc + 1;
        s0 = (a <= last_e[id] + 1) ? last_e[id] + gsz[id] + 1 : a;
        for (int i = 0; i < wsz[id]; i++) begin
            e.id     = id;
            e.idx    = i;
            e.edge_n = s0 + i * (gsz[id] + 1);
            e.b      = (msb[id] != 0) ? w[wsz[id] - 1 - i] : w[i];
            e.st     = (i == 0);
            e.dn     = (i == wsz[id] - 1);
            expq.push_back(e);
        end
        last_e[id] = s0 + (wsz[id] - 1) * (gsz[id] + 1);
        if (id == 0) wq.push_back(w);
        @(negedge clk);
    endtask

    // Drop valid and scramble data so a word in flight cannot depend on the bus afterwards.
    task automatic idle(input int id);
        set_in(id, $urandom, 1'b0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(expq.size()), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n = 1'b0;
        sv    = '0;
        sd0   = '0;
        sd1   = '0;
        sd2   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(rdy), 64'(0));
        chk("reset_busy", 64'(bsy), 64'(0));
        chk("reset_dval", 64'(dv), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(rdy), 64'(3'b111));

        // Single 32-bit word, contiguous MSB-first.
        send(0, 32'hA5A50F0F);
        idle(0);
        chk("busy_in_flight", 64'(bsy[0]), 64'(1));
        wait_drain();
        @(negedge clk);
        chk("busy_after_word", 64'(bsy[0]), 64'(0));

        // Two words back-to-back: second waits in holding register.
        send(0, 32'h12345678);
        send(0, 32'h9ABCDEF0);
        idle(0);
        chk("ready_low_hold_full", 64'(rdy[0]), 64'(0));
        chk("busy_hold_full", 64'(bsy[0]), 64'(1));
        wait_drain();

        // GAP=2: strobe every third cycle; then a burst to exercise gap after last bit.
        send(1, 32'h000000C3);
        idle(1);
        wait_drain();
        send(1, 32'h0000005A);
        send(1, 32'h00000081);
        send(1, 32'h000000F0);
        idle(1);
        wait_drain();

        // LSB-first.
        send(2, 32'h00000001);
        idle(2);
        wait_drain();
        send(2, 32'h00000096);
        send(2, 32'h0000003C);
        idle(2);
        wait_drain();

        // Reset in the middle of a word.
        base = strobes[0];
        send(0, 32'hFFFFFFFF);
        idle(0);
        n = 0;
        while (strobes[0] - base < 11 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("strobes_before_reset", 64'(strobes[0] - base >= 11), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midword_reset_dval", 64'(dv[0]), 64'(0));
        chk("midword_reset_busy", 64'(bsy[0]), 64'(0));
        chk("midword_reset_ready", 64'(rdy[0]), 64'(0));
        expq.delete();
        wq.delete();
        for (int i = 0; i < 3; i++) last_e[i] = -1000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midword_reset", 64'(rdy[0]), 64'(1));
        base = strobes[0];
        repeat (40) @(negedge clk);
        chk("no_strobes_after_reset", 64'(strobes[0] - base), 64'(0));

        // 100 words with valid held high, occasional idle gaps of random length.
        for (int k = 0; k < 100; k++) begin
            send(0, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                idle(0);
                repeat ($urandom_range(1, 40)) @(negedge clk);
            end
        end
        idle(0);
        wait_drain();
        chk("words_unreceived", 64'(wq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning word length in bits (legal range 4..64).
REQ-002 SHALL have parameter GAP, default 0, meaning idle cycles inserted between consecutive bits (legal range 0..15).
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning bit order on the serial side (1 = bit WIDTH-1 first, 0 = bit 0 first).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port s_data_i  input  WIDTH  parallel word to send.
REQ-007 SHALL have port s_valid_i  input  1  s_data_i is valid.
REQ-008 SHALL have port s_ready_o  output  1  block accepts a word this cycle.
REQ-009 SHALL have port data_o  output  1  serial bit; meaningful only when data_val_o=1.
REQ-010 SHALL have port data_val_o  output  1  single-cycle strobe qualifying each bit; drives a receiver's bit-valid input directly.
REQ-011 SHALL have port word_start_o  output  1  coincides with the data_val_o of bit 0 of each word.
REQ-012 SHALL have port word_done_o  output  1  coincides with the data_val_o of the last bit of each word.
REQ-013 SHALL have port busy_o  output  1  a word is in the shift register or the holding register.

Function
REQ-014 SHALL transfer a word when s_valid_i=1 and s_ready_o=1 on the same rising edge; s_ready_o does not depend on s_valid_i.
REQ-015 SHALL hold two word slots: shift register and holding register; s_ready_o = not holding-valid.
REQ-016 SHALL route an accepted word straight into the shift register when that register is empty or emits its last bit that cycle; otherwise into the holding register.
REQ-017 SHALL assert data_val_o for the first bit on the cycle after acceptance into an empty block (latency 1).
REQ-018 SHALL use FSM states IDLE, SHIFT, GAP: IDLE->SHIFT on load; SHIFT->GAP after each bit when GAP>0; GAP->SHIFT after exactly GAP cycles; SHIFT->IDLE after last bit with no word pending.
REQ-019 SHALL count bits 0..WIDTH-1 in a counter of $clog2(WIDTH) bits, clearing it on each word load.
REQ-020 SHALL, after the last bit with a word pending, send that word's bit 0 exactly GAP+1 cycles after the previous bit, producing a contiguous stream when GAP=0.
REQ-021 SHALL keep data_val_o, word_start_o and word_done_o at 0 in IDLE and GAP.
REQ-022 SHALL hold data_o at 0 whenever data_val_o=0.
REQ-023 SHALL sample s_data_i only on the accepting edge; later changes to s_data_i do not affect a word in flight.
REQ-024 SHALL, when accept and last-bit emission coincide with the holding register full, keep s_ready_o=0 that cycle; no word is lost or duplicated.
REQ-025 SHALL drive all outputs from registers (no combinational path input->output).

Reset
REQ-026 SHALL, while rst_n=0, force FSM=IDLE, counter=0, both slots empty, data_o=0, data_val_o=0, word_start_o=0, word_done_o=0, busy_o=0, s_ready_o=0.
REQ-027 SHALL drive s_ready_o=1 on the first rising edge after rst_n deasserts.
REQ-028 SHALL discard a word in flight when reset asserts mid-word; no partial word resumes afterwards.

Structure
REQ-029 SHALL take the FSM state enum (IDLE, SHIFT, GAP) from a shared package, serializer_pkg.
REQ-030 SHALL be one flat module with no sub-modules; the receiver is instantiated only in the testbench.

Verification
REQ-031 SHALL check: WIDTH=32, GAP=0, word 0xA5A50F0F -> 32 consecutive data_val_o cycles starting 1 cycle after accept, bits MSB-first, word_done_o on the 32nd; the loopback receiver's 32-bit register reads 0xA5A50F0F.
REQ-032 SHALL check: words 0x12345678 then 0x9ABCDEF0 presented back-to-back -> 64 contiguous data_val_o cycles; s_ready_o low while holding full; word_start_o at cycles 1 and 33.
REQ-033 SHALL check: GAP=2, WIDTH=8, word 0xC3 -> data_val_o every 3rd cycle, 8 strobes, bits 1,1,0,0,0,0,1,1.
REQ-034 SHALL check: MSB_FIRST=0, WIDTH=8, word 0x01 -> first bit 1, remaining seven 0.
REQ-035 SHALL check: rst_n low after bit 10 of 0xFFFFFFFF -> data_val_o=0 and busy_o=0 immediately; s_ready_o=1 one edge after release; no stray strobes.
REQ-036 SHALL check: s_valid_i held high for 100 random words with random gaps -> every word received exactly once, in order.
